core_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the npc core: drives fetch, decode, execute, memory and writeback

---
 rtl/core_ctrl_fsm_pkg.sv | 35 +++
 rtl/ctrl_bus_timer.sv | 38 +++
 rtl/core_ctrl_fsm.sv | 165 ++++++++++++++++
 tb/tb_core_ctrl_fsm.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ctrl_fsm_pkg.sv
// Shared definitions for the npc core control sequencer: state encodings,
// halt cause codes and the decoder flag bundle.
package core_ctrl_fsm_pkg;

    localparam logic [3:0] CTRL_RESET      = 4'd0;
    localparam logic [3:0] CTRL_FETCH_REQ  = 4'd1;
    localparam logic [3:0] CTRL_FETCH_WAIT = 4'd2;
    localparam logic [3:0] CTRL_DECODE     = 4'd3;
    localparam logic [3:0] CTRL_EXEC       = 4'd4;
    localparam logic [3:0] CTRL_MEM_REQ    = 4'd5;
    localparam logic [3:0] CTRL_MEM_WAIT   = 4'd6;
    localparam logic [3:0] CTRL_WB         = 4'd7;
    localparam logic [3:0] CTRL_HALT       = 4'd8;

    localparam logic [1:0] HALT_NONE    = 2'd0;
    localparam logic [1:0] HALT_EBREAK  = 2'd1;
    localparam logic [1:0] HALT_ILLEGAL = 2'd2;
    localparam logic [1:0] HALT_TIMEOUT = 2'd3;

    typedef struct packed {
        logic is_load;
        logic mem_wen;
        logic is_mul;
        logic is_ebreak;
        logic not_ipl;
        logic reg_wen;
    } dec_flags_t;

    // States in which a bus transaction is outstanding and the timeout runs.
    function automatic logic is_bus_state(input logic [3:0] state);
        return (state == CTRL_FETCH_REQ) || (state == CTRL_FETCH_WAIT) ||
               (state == CTRL_MEM_REQ)   || (state == CTRL_MEM_WAIT);
    endfunction

endpackage

// File: rtl/ctrl_bus_timer.sv
// Bus watchdog: counts cycles while enabled, flags expiry on the
// BUS_TIMEOUT-th consecutive enabled cycle since the last clear.
module ctrl_bus_timer #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(BUS_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));

    // NOTE: always_comb assigns every output a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer for the npc core,
// with IFU/LSU valid-ready handshakes, sticky halt with cause and instret counter.
module core_ctrl_fsm
    import core_ctrl_fsm_pkg::*;
#(
    parameter int MUL_CYCLES  = 4,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_req_valid,
    input  logic        ifu_req_ready,
    input  logic        ifu_rsp_valid,
    output logic        inst_latch_en,
    input  logic        dec_is_load,
    input  logic        dec_mem_wen,
    input  logic        dec_is_mul,
    input  logic        dec_is_ebreak,
    input  logic        dec_inst_not_ipl,
    input  logic        dec_reg_wen,
    output logic        lsu_req_valid,
    input  logic        lsu_req_ready,
    input  logic        lsu_rsp_valid,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [63:0] instret,
    output logic [3:0]  state_o
);

    localparam int MUL_W = $clog2(MUL_CYCLES + 1);

    logic [3:0]       state_q, state_d;
    logic [1:0]       halt_code_q, halt_code_d;
    logic [MUL_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [63:0]      instret_q, instret_d;
    logic             bus_busy;
    logic             bus_expired;
    dec_flags_t       dec;

    assign dec = '{
        is_load:   dec_is_load,
        mem_wen:   dec_mem_wen,
        is_mul:    dec_is_mul,
        is_ebreak: dec_is_ebreak,
        not_ipl:   dec_inst_not_ipl,
        reg_wen:   dec_reg_wen
    };

    // Leaving the bus states clears the timer, so each REQ entry starts from zero.
    assign bus_busy = is_bus_state(state_q);

    ctrl_bus_timer #(
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) u_bus_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!bus_busy),
        .enable_i  (bus_busy),
        .expired_o (bus_expired)
    );

    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        mul_cnt_d   = mul_cnt_q;
        instret_d   = instret_q;
        case (state_q)
            CTRL_RESET: begin
                state_d = CTRL_FETCH_REQ;
            end
            CTRL_FETCH_REQ: begin
                if (bus_expired) begin
                    state_d     = CTRL_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end else if (ifu_req_ready) begin
                    state_d = CTRL_FETCH_WAIT;
                end
            end
            CTRL_FETCH_WAIT: begin
                if (bus_expired) begin
                    state_d     = CTRL_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end else if (ifu_rsp_valid) begin
                    state_d = CTRL_DECODE;
                end
            end
            CTRL_DECODE: begin
                if (dec.is_ebreak) begin
                    state_d     = CTRL_HALT;
                    halt_code_d = HALT_EBREAK;
                end else if (dec.not_ipl) begin
                    state_d     = CTRL_HALT;
                    halt_code_d = HALT_ILLEGAL;
                end else begin
                    state_d   = CTRL_EXEC;
                    mul_cnt_d = dec.is_mul ? MUL_W'(MUL_CYCLES - 1) : '0;
                end
            end
            CTRL_EXEC: begin
                if (mul_cnt_q != '0) begin
                    mul_cnt_d = mul_cnt_q - MUL_W'(1);
                end else if (dec.is_load || dec.mem_wen) begin
                    state_d = CTRL_MEM_REQ;
                end else begin
                    state_d = CTRL_WB;
                end
            end
            CTRL_MEM_REQ: begin
                if (bus_expired) begin
                    state_d     = CTRL_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end else if (lsu_req_ready) begin
                    state_d = CTRL_MEM_WAIT;
                end
            end
            CTRL_MEM_WAIT: begin
                if (bus_expired) begin
                    state_d     = CTRL_HALT;
                    halt_code_d = HALT_TIMEOUT;
                end else if (lsu_rsp_valid) begin
                    state_d = CTRL_WB;
                end
            end
            CTRL_WB: begin
                instret_d = instret_q + 64'd1;
                state_d   = CTRL_FETCH_REQ;
            end
            CTRL_HALT: begin
                state_d = CTRL_HALT;
            end
            default: begin
                state_d = CTRL_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CTRL_RESET;
            halt_code_q <= HALT_NONE;
            mul_cnt_q   <= '0;
            instret_q   <= '0;
        end else begin
            state_q     <= state_d;
            halt_code_q <= halt_code_d;
            mul_cnt_q   <= mul_cnt_d;
            instret_q   <= instret_d;
        end
    end

    // Requests and strobes decode registered state only; the instruction-register
    // load must follow the response in the same cycle so DECODE sees the new word.
    assign ifu_req_valid = (state_q == CTRL_FETCH_REQ);
    assign lsu_req_valid = (state_q == CTRL_MEM_REQ);
    assign inst_latch_en = (state_q == CTRL_FETCH_WAIT) && ifu_rsp_valid && !bus_expired;
    assign rf_wen        = (state_q == CTRL_WB) && dec.reg_wen && !dec.mem_wen;
    assign pc_wen        = (state_q == CTRL_WB);
    assign halt          = (state_q == CTRL_HALT);
    assign halt_code     = halt_code_q;
    assign instret       = instret_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Directed bench for core_ctrl_fsm: bus responders with programmable delays,
// per-instruction latency/strobe checks, halt causes, timeout and reset abort.
module tb_core_ctrl_fsm;
    import core_ctrl_fsm_pkg::*;

    localparam int MUL_CYCLES  = 4;
    localparam int BUS_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, inst_latch_en;
    logic        dec_is_load, dec_mem_wen, dec_is_mul, dec_is_ebreak, dec_inst_not_ipl, dec_reg_wen;
    logic        lsu_req_valid, lsu_req_ready, lsu_rsp_valid;
    logic        rf_wen, pc_wen, halt;
    logic [1:0]  halt_code;
    logic [63:0] instret;
    logic [3:0]  state_o;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [63:0] exp_instret = '0;

    always #5 clk = ~clk;

    core_ctrl_fsm #(
        .MUL_CYCLES  (MUL_CYCLES),
        .BUS_TIMEOUT (BUS_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ifu_req_valid    (ifu_req_valid),
        .ifu_req_ready    (ifu_req_ready),
        .ifu_rsp_valid    (ifu_rsp_valid),
        .inst_latch_en    (inst_latch_en),
        .dec_is_load      (dec_is_load),
        .dec_mem_wen      (dec_mem_wen),
        .dec_is_mul       (dec_is_mul),
        .dec_is_ebreak    (dec_is_ebreak),
        .dec_inst_not_ipl (dec_inst_not_ipl),
        .dec_reg_wen      (dec_reg_wen),
        .lsu_req_valid    (lsu_req_valid),
        .lsu_req_ready    (lsu_req_ready),
        .lsu_rsp_valid    (lsu_rsp_valid),
        .rf_wen           (rf_wen),
        .pc_wen           (pc_wen),
        .halt             (halt),
        .halt_code        (halt_code),
        .instret          (instret),
        .state_o          (state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic idle_bus();
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_req_ready = 1'b0;
        lsu_rsp_valid = 1'b0;
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic mul,
                           input logic ebrk, input logic ill, input logic rwen);
        dec_is_load      = ld;
        dec_mem_wen      = st;
        dec_is_mul       = mul;
        dec_is_ebreak    = ebrk;
        dec_inst_not_ipl = ill;
        dec_reg_wen      = rwen;
    endtask

    // Leaves the bench at edge+1 of cycle 1 (FETCH_REQ) of the first instruction.
    task automatic apply_reset(input string tag);
        idle_bus();
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check({tag, "_state"}, 64'(state_o), 64'(CTRL_RESET));
        check({tag, "_outs"}, 64'({ifu_req_valid, inst_latch_en, lsu_req_valid,
                                   rf_wen, pc_wen, halt, halt_code}), 64'd0);
        check({tag, "_instret"}, instret, 64'd0);
        rst = 1'b0;
        exp_instret = '0;
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction with a zero-wait IFU and an LSU that raises ready after
    // ready_dly refused cycles and responds rsp_dly cycles after acceptance.
    task automatic run_instr(input string tag, input int ready_dly, input int rsp_dly,
                             input int exp_end, input logic exp_rf, input int exp_lsu_cyc,
                             input logic [1:0] exp_code);
        int   ifu_acc, lsu_acc, lsu_seen, end_cyc, latch_cnt, rf_cnt, pc_cnt;
        logic done;
        logic rf_at_end;
        ifu_acc   = -1;
        lsu_acc   = -1;
        lsu_seen  = 0;
        end_cyc   = -1;
        latch_cnt = 0;
        rf_cnt    = 0;
        pc_cnt    = 0;
        done      = 1'b0;
        rf_at_end = 1'b0;
        for (int cyc = 1; cyc <= 100 && !done; cyc++) begin
            ifu_req_ready = ifu_req_valid;
            ifu_rsp_valid = (ifu_acc >= 0) && (cyc == ifu_acc + 1);
            if (lsu_req_valid) lsu_seen++;
            lsu_req_ready = lsu_req_valid && (lsu_seen > ready_dly);
            lsu_rsp_valid = (lsu_acc >= 0) && (cyc == lsu_acc + rsp_dly);
            if (ifu_req_valid && ifu_req_ready) ifu_acc = cyc;
            if (lsu_req_valid && lsu_req_ready) lsu_acc = cyc;
            #1;
            latch_cnt += int'(inst_latch_en);
            rf_cnt    += int'(rf_wen);
            pc_cnt    += int'(pc_wen);
            if (pc_wen || halt) begin
                done      = 1'b1;
                end_cyc   = cyc;
                rf_at_end = rf_wen;
            end
            @(posedge clk);
            #1;
        end
        idle_bus();
        check({tag, "_end_cycle"}, 64'(end_cyc), 64'(exp_end));
        check({tag, "_halt_code"}, 64'(halt_code), 64'(exp_code));
        if (exp_code == HALT_NONE) begin
            exp_instret = exp_instret + 64'd1;
            check({tag, "_rf_wen_wb"}, 64'(rf_at_end), 64'(exp_rf));
            check({tag, "_rf_wen_cnt"}, 64'(rf_cnt), 64'(exp_rf));
            check({tag, "_pc_wen_cnt"}, 64'(pc_cnt), 64'd1);
            check({tag, "_latch_cnt"}, 64'(latch_cnt), 64'd1);
            check({tag, "_lsu_valid_cyc"}, 64'(lsu_seen), 64'(exp_lsu_cyc));
            check({tag, "_next_fetch"}, 64'({ifu_req_valid, pc_wen, rf_wen}), 64'b100);
        end else begin
            check({tag, "_pc_wen_cnt"}, 64'(pc_cnt), 64'd0);
            check({tag, "_halt"}, 64'(halt), 64'd1);
        end
        check({tag, "_instret"}, instret, exp_instret);
    endtask

    // Fetch with the IFU refusing, except optionally a ready in cycle ready_cyc.
    task automatic run_timeout(input string tag, input int ready_cyc);
        int freq_cnt, halt_cyc;
        freq_cnt = 0;
        halt_cyc = -1;
        for (int cyc = 1; cyc <= 50 && halt_cyc < 0; cyc++) begin
            ifu_req_ready = (cyc == ready_cyc);
            ifu_rsp_valid = 1'b1;
            #1;
            if (ifu_req_valid) freq_cnt++;
            if (halt) halt_cyc = cyc;
            @(posedge clk);
            #1;
        end
        idle_bus();
        check({tag, "_freq_cycles"}, 64'(freq_cnt), 64'(BUS_TIMEOUT));
        check({tag, "_halt_cycle"}, 64'(halt_cyc), 64'(BUS_TIMEOUT + 1));
        check({tag, "_halt_code"}, 64'(halt_code), 64'(HALT_TIMEOUT));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        idle_bus();
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;

        apply_reset("reset0");
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("addi", 0, 1, 5, 1'b1, 0, HALT_NONE);
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("lw_slow", 3, 2, 11, 1'b1, 4, HALT_NONE);
        set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        run_instr("lw_fast", 0, 1, 7, 1'b1, 1, HALT_NONE);
        set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_instr("sd", 0, 1, 7, 1'b0, 1, HALT_NONE);
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_instr("mul", 0, 1, 4 + MUL_CYCLES, 1'b1, 0, HALT_NONE);

        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_instr("ebreak", 0, 1, 4, 1'b0, 0, HALT_EBREAK);
        bad = 0;
        ifu_req_ready = 1'b1;
        ifu_rsp_valid = 1'b1;
        lsu_req_ready = 1'b1;
        lsu_rsp_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (!halt || halt_code != HALT_EBREAK || ifu_req_valid || lsu_req_valid ||
                rf_wen || pc_wen || inst_latch_en || instret != exp_instret) bad++;
        end
        check("ebreak_hold_violations", 64'(bad), 64'd0);

        apply_reset("reset1");
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        run_instr("illegal", 0, 1, 4, 1'b0, 0, HALT_ILLEGAL);

        apply_reset("reset2");
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        run_instr("ebreak_over_illegal", 0, 1, 4, 1'b0, 0, HALT_EBREAK);

        apply_reset("reset3");
        run_timeout("timeout", 0);
        apply_reset("reset4");
        run_timeout("timeout_vs_ready", BUS_TIMEOUT);

        apply_reset("reset5");
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ifu_req_ready = 1'b1;
        @(posedge clk);
        #1;
        ifu_req_ready = 1'b0;
        check("abort_in_fwait", 64'(state_o), 64'(CTRL_FETCH_WAIT));
        rst = 1'b1;
        ifu_rsp_valid = 1'b1;
        @(posedge clk);
        #1;
        check("abort_state", 64'(state_o), 64'(CTRL_RESET));
        check("abort_outs", 64'({ifu_req_valid, inst_latch_en, lsu_req_valid,
                                 rf_wen, pc_wen, halt, halt_code}), 64'd0);
        rst = 1'b0;
        ifu_rsp_valid = 1'b0;
        exp_instret = '0;
        @(posedge clk);
        #1;
        run_instr("addi_after_abort", 0, 1, 5, 1'b1, 0, HALT_NONE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
